// File: rtl/prescaled_counter_pkg.sv
// prescaled_counter_pkg
//   Shared definitions for the prescaled counter and its tick generator:
//   the count-direction encoding and a clog2 helper that never returns 0.
package prescaled_counter_pkg;

  // Encoding of the dir input.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Width of a counter that must hold the values 0 .. n-1.
  // The result is never below 1, so a divide-by-1 prescaler still has a
  // legal one-bit register.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen
//   Clock-enabled prescaler. The internal phase counter runs from 0 to
//   CYCLES_PER_TICK-1 on enabled edges and then wraps. The phase is held
//   while ce is low, so the period resumes where it stopped.
//
//   Ports
//     clk   in   system clock, rising edge
//     rst   in   asynchronous active-high reset (phase <- 0)
//     ce    in   count enable
//     clr   in   synchronous clear of the phase; overrides ce
//     tick  out  high during the cycle whose rising edge wraps the phase.
//                It is combinational from ce/clr; the parent registers it
//                together with the value step it triggers.
module tick_gen
  import prescaled_counter_pkg::*;
#(
  parameter int CYCLES_PER_TICK = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = clog2_min1(CYCLES_PER_TICK);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_TICK - 1);

  logic [CNT_W-1:0] prescale_cnt_d;
  logic [CNT_W-1:0] prescale_cnt_q;

  // NOTE: every signal driven in always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    prescale_cnt_d = prescale_cnt_q;
    tick           = 1'b0;
    if (clr) begin
      prescale_cnt_d = '0;
    end else if (ce) begin
      if (prescale_cnt_q == LAST) begin
        // With a divide-by-1 prescaler LAST is 0, so this branch is taken
        // on every enabled edge and the phase never leaves 0.
        prescale_cnt_d = '0;
        tick           = 1'b1;
      end else begin
        prescale_cnt_d = prescale_cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples its pre-edge inputs, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_cnt_q <= '0;
    end else begin
      prescale_cnt_q <= prescale_cnt_d;
    end
  end

endmodule

// File: rtl/prescaled_counter.sv
// prescaled_counter
//   Divides clk down to TICK_HZ with tick_gen and steps a WIDTH-bit value
//   counter once per tick, up or down, wrapping or saturating at the
//   limits. A synchronous load overrides counting and restarts the
//   prescaler period. All outputs are registered.
//
//   Parameters
//     CLK_FREQ    input clock frequency in Hz
//     TICK_HZ     step rate in Hz; CYCLES_PER_TICK = CLK_FREQ / TICK_HZ
//     WIDTH       value counter width
//     SATURATE    0 = wrap at the limits, 1 = hold at the limits
//
//   Ports
//     clk         in   system clock, rising edge
//     rst         in   asynchronous active-high reset
//     ce          in   count enable for prescaler and value counter
//     dir         in   0 = up, 1 = down, sampled on stepping edges
//     load        in   synchronous parallel load, highest priority
//     load_value  in   value written on load
//     value       out  current count
//     tick        out  one-cycle strobe per prescaler rollover
//     tc          out  one-cycle strobe per overflow/underflow attempt
module prescaled_counter
  import prescaled_counter_pkg::*;
#(
  parameter int CLK_FREQ = 125_000_000,
  parameter int TICK_HZ  = 1,
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             tick,
  output logic             tc
);

  localparam int CYCLES_PER_TICK = CLK_FREQ / TICK_HZ;
  localparam logic [WIDTH-1:0] MAX_VALUE = '1;

  // A tick rate above the clock rate cannot be produced by a divider.
  if (CYCLES_PER_TICK < 1) begin : g_bad_cfg
    $fatal(1, "prescaled_counter: TICK_HZ exceeds CLK_FREQ");
  end

  logic             step;
  logic [WIDTH-1:0] value_d, value_q;
  logic             tick_d, tick_q;
  logic             tc_d, tc_q;

  // Loading clears the prescaler, so the first step after a load comes a
  // full period later.
  tick_gen #(
    .CYCLES_PER_TICK(CYCLES_PER_TICK)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .clr (load),
    .tick(step)
  );

  always_comb begin
    value_d = value_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
    if (load) begin
      value_d = load_value;
    end else if (step) begin
      // step is already gated by ce and load inside tick_gen.
      tick_d = 1'b1;
      if (dir_e'(dir) == DIR_UP) begin
        if (value_q == MAX_VALUE) begin
          tc_d = 1'b1;
          if (!SATURATE) value_d = '0;
        end else begin
          value_d = value_q + WIDTH'(1);
        end
      end else begin
        if (value_q == '0) begin
          tc_d = 1'b1;
          if (!SATURATE) value_d = MAX_VALUE;
        end else begin
          value_d = value_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      value_q <= value_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
    end
  end

  assign value = value_q;
  assign tick  = tick_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// tb_prescaled_counter
//   Directed bench for prescaled_counter with CYCLES_PER_TICK=5 (wrap and
//   saturate builds) and CYCLES_PER_TICK=1. Inputs change and outputs are
//   sampled 1 time unit after each rising edge.
module tb_prescaled_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Wrap build, CYCLES_PER_TICK = 5
  logic       w_ce = 0, w_dir = 0, w_load = 0;
  logic [3:0] w_lv = '0;
  logic [3:0] w_value;
  logic       w_tick, w_tc;

  // Saturate build, CYCLES_PER_TICK = 5
  logic       s_ce = 0, s_dir = 0, s_load = 0;
  logic [3:0] s_lv = '0;
  logic [3:0] s_value;
  logic       s_tick, s_tc;

  // Divide-by-1 build
  logic       f_ce = 0, f_dir = 0, f_load = 0;
  logic [3:0] f_lv = '0;
  logic [3:0] f_value;
  logic       f_tick, f_tc;

  prescaled_counter #(.CLK_FREQ(10), .TICK_HZ(2), .WIDTH(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .ce(w_ce), .dir(w_dir), .load(w_load),
    .load_value(w_lv), .value(w_value), .tick(w_tick), .tc(w_tc)
  );

  prescaled_counter #(.CLK_FREQ(10), .TICK_HZ(2), .WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .ce(s_ce), .dir(s_dir), .load(s_load),
    .load_value(s_lv), .value(s_value), .tick(s_tick), .tc(s_tc)
  );

  prescaled_counter #(.CLK_FREQ(1), .TICK_HZ(1), .WIDTH(4), .SATURATE(1'b0)) u_fast (
    .clk(clk), .rst(rst), .ce(f_ce), .dir(f_dir), .load(f_load),
    .load_value(f_lv), .value(f_value), .tick(f_tick), .tc(f_tc)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [3:0] act_v, input logic act_t,
                       input logic act_c, input logic [3:0] exp_v, input logic exp_t,
                       input logic exp_c);
    checks++;
    if (act_v !== exp_v || act_t !== exp_t || act_c !== exp_c) begin
      errors++;
      $display("FAIL %s: got value=%0d tick=%0b tc=%0b, expected value=%0d tick=%0b tc=%0b",
               name, act_v, act_t, act_c, exp_v, exp_t, exp_c);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       ce;
    logic       dir;
    logic       load;
    logic [3:0] lv;
    logic [3:0] exp_value;
    logic       exp_tick;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ce, input logic dir, input logic load, input logic [3:0] lv,
                     input logic [3:0] ev, input logic et, input logic ec);
    vec_t v;
    v.ce = ce; v.dir = dir; v.load = load; v.lv = lv;
    v.exp_value = ev; v.exp_tick = et; v.exp_tc = ec;
    vecs.push_back(v);
  endtask

  initial begin
    // ---------------- reset state ----------------
    #12;
    check("reset_wrap", w_value, w_tick, w_tc, 4'd0, 1'b0, 1'b0);
    check("reset_sat",  s_value, s_tick, s_tc, 4'd0, 1'b0, 1'b0);
    check("reset_fast", f_value, f_tick, f_tc, 4'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ---------------- table: up wrap, load priority, dir mid-period ----------------
    add(0, 0, 1, 4'd14, 4'd14, 0, 0);                 // load 14, phase 0
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 4'd14, 0, 0);
    add(1, 0, 0, 0, 4'd15, 1, 0);                     // 5th enabled edge steps
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 4'd15, 0, 0);
    add(1, 0, 0, 0, 4'd0, 1, 1);                      // wrap 15 -> 0 with tc
    add(1, 0, 0, 0, 4'd0, 0, 0);                      // strobes one cycle only, phase 1
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 4'd0, 0, 0);   // phase reaches 4
    add(1, 0, 1, 4'd9, 4'd9, 0, 0);                   // load wins over rollover
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 4'd9, 0, 0);
    add(1, 0, 0, 0, 4'd10, 1, 0);                     // full period after load
    for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 4'd10, 0, 0);  // dir down mid-period
    add(1, 0, 0, 0, 4'd11, 1, 0);                     // only stepping-edge dir counts
    for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 4'd11, 0, 0);
    add(1, 1, 0, 0, 4'd10, 1, 0);                     // down step

    foreach (vecs[i]) begin
      w_ce = vecs[i].ce; w_dir = vecs[i].dir; w_load = vecs[i].load; w_lv = vecs[i].lv;
      tick_clk();
      check($sformatf("vec%0d", i), w_value, w_tick, w_tc,
            vecs[i].exp_value, vecs[i].exp_tick, vecs[i].exp_tc);
    end

    // ---------------- enable gating ----------------
    w_ce = 0; w_dir = 0; w_load = 1; w_lv = 4'd0;
    tick_clk();
    w_load = 0; w_ce = 1;
    repeat (3) tick_clk();                            // phase 3
    check("gate_pre", w_value, w_tick, w_tc, 4'd0, 1'b0, 1'b0);
    w_ce = 0;
    for (int i = 0; i < 20; i++) begin
      tick_clk();
      check($sformatf("gate_off%0d", i), w_value, w_tick, w_tc, 4'd0, 1'b0, 1'b0);
    end
    w_ce = 1;
    tick_clk();
    check("gate_resume1", w_value, w_tick, w_tc, 4'd0, 1'b0, 1'b0);
    tick_clk();
    check("gate_resume2", w_value, w_tick, w_tc, 4'd1, 1'b1, 1'b0);

    // ---------------- reset mid-count ----------------
    w_ce = 0; w_load = 1; w_lv = 4'd0;
    tick_clk();
    w_load = 0; w_ce = 1;
    repeat (15) tick_clk();
    check("rst_before", w_value, w_tick, w_tc, 4'd3, 1'b1, 1'b0);
    rst = 1'b1;                                       // between edges
    #1;
    check("rst_async", w_value, w_tick, w_tc, 4'd0, 1'b0, 1'b0);
    tick_clk();
    check("rst_held", w_value, w_tick, w_tc, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      check($sformatf("rst_release%0d", i), w_value, w_tick, w_tc, 4'd0, 1'b0, 1'b0);
    end
    tick_clk();
    check("rst_first_step", w_value, w_tick, w_tc, 4'd1, 1'b1, 1'b0);
    w_ce = 0;

    // ---------------- down saturate ----------------
    s_load = 1; s_lv = 4'd1;
    tick_clk();
    s_load = 0; s_ce = 1; s_dir = 1;
    repeat (4) tick_clk();
    check("sat_down_wait", s_value, s_tick, s_tc, 4'd1, 1'b0, 1'b0);
    tick_clk();
    check("sat_down_to0", s_value, s_tick, s_tc, 4'd0, 1'b1, 1'b0);
    repeat (5) tick_clk();
    check("sat_down_hold", s_value, s_tick, s_tc, 4'd0, 1'b1, 1'b1);
    tick_clk();
    check("sat_down_after", s_value, s_tick, s_tc, 4'd0, 1'b0, 1'b0);
    // up saturate at max
    s_ce = 0; s_load = 1; s_lv = 4'd15;
    tick_clk();
    s_load = 0; s_ce = 1; s_dir = 0;
    repeat (5) tick_clk();
    check("sat_up_hold", s_value, s_tick, s_tc, 4'd15, 1'b1, 1'b1);
    s_ce = 0;

    // ---------------- divide-by-1 ----------------
    f_load = 1; f_lv = 4'd13;
    tick_clk();
    check("fast_load", f_value, f_tick, f_tc, 4'd13, 1'b0, 1'b0);
    f_load = 0; f_ce = 1; f_dir = 0;
    tick_clk();
    check("fast_14", f_value, f_tick, f_tc, 4'd14, 1'b1, 1'b0);
    tick_clk();
    check("fast_15", f_value, f_tick, f_tc, 4'd15, 1'b1, 1'b0);
    tick_clk();
    check("fast_wrap", f_value, f_tick, f_tc, 4'd0, 1'b1, 1'b1);
    tick_clk();
    check("fast_1", f_value, f_tick, f_tc, 4'd1, 1'b1, 1'b0);
    f_dir = 1;
    tick_clk();
    check("fast_down", f_value, f_tick, f_tc, 4'd0, 1'b1, 1'b0);
    tick_clk();
    check("fast_underflow", f_value, f_tick, f_tc, 4'd15, 1'b1, 1'b1);
    f_ce = 0;
    tick_clk();
    check("fast_disabled", f_value, f_tick, f_tc, 4'd15, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
